// File: rtl/wb_slave_ram.sv
// wb_slave_ram: Wishbone B4 classic single-port word-addressed RAM slave.
// Answers single read and single write cycles with a registered ack_o
// after WAIT_STATES extra cycles, and with err_o for out-of-window addresses.
// Optional byte-lane writes are enabled by defining WB_SLAVE_RAM_SEL_EN;
// without it sel_i is ignored and every write updates the full word.

module wb_slave_ram #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int BASE_ADDR   = 0,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    ack_o,
   output logic                    err_o
);

   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NUM_LANES = DATA_WIDTH / 8;

   // Window bounds are held one bit wider than the address so that
   // BASE_ADDR+DEPTH never wraps back into the low address range.
   localparam logic [ADDR_WIDTH:0] WIN_LO    = (ADDR_WIDTH+1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] WIN_SIZE  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [3:0]          WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t state, next_state;
   logic [3:0] wait_cnt, next_wait_cnt;

   logic request;
   logic enter_resp;
   logic do_write;
   logic addr_hit;

   logic [ADDR_WIDTH:0] adr_ext;
   logic [ADDR_WIDTH:0] adr_offset;
   logic [IDX_W-1:0]    word_idx;

   // Storage starts all-zero at configuration and is never cleared by reset.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   assign request = cyc_i & stb_i;

   // Address decode: an address below the base wraps to a huge offset, so a
   // single unsigned compare against the window size covers both bounds.
   always_comb begin
      adr_ext    = {1'b0, adr_i};
      adr_offset = adr_ext - WIN_LO;
      addr_hit   = (adr_offset < WIN_SIZE);
      word_idx   = adr_offset[IDX_W-1:0];
   end

   // Next-state logic: count wait states, abort if the master withdraws,
   // and always return to idle one cycle after responding.
   always_comb begin
      next_state    = state;
      next_wait_cnt = wait_cnt;
      enter_resp    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (request) begin
               if (WAIT_STATES == 0) begin
                  next_state = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  next_state    = ST_WAIT;
                  next_wait_cnt = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!request) begin
               next_state    = ST_IDLE;
               next_wait_cnt = 4'd0;
            end else if (wait_cnt == 4'd0) begin
               next_state = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               next_wait_cnt = wait_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state    = ST_IDLE;
            next_wait_cnt = 4'd0;
         end
      endcase
      do_write = enter_resp & addr_hit & we_i;
   end

   // State, counter and registered bus responses; reset drops any response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
         dat_o    <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_wait_cnt;
         ack_o    <= enter_resp & addr_hit;
         err_o    <= enter_resp & ~addr_hit;
         if (enter_resp && addr_hit && !we_i) begin
            dat_o <= mem[word_idx];
         end
      end
   end

`ifdef WB_SLAVE_RAM_SEL_EN
   // Memory write port: only the selected byte lanes are updated.
   always_ff @(posedge clk_i) begin
      if (!rst_i && do_write) begin
         for (int k = 0; k < NUM_LANES; k++) begin
            if (sel_i[k]) begin
               mem[word_idx][8*k +: 8] <= dat_i[8*k +: 8];
            end
         end
      end
   end
`else
   logic unused_sel;
   assign unused_sel = ^sel_i;

   // Memory write port: the whole word is replaced on every write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && do_write) begin
         mem[word_idx] <= dat_i;
      end
   end
`endif

endmodule
